// File: rtl/capture_controller.sv
// Logic analyzer capture/trigger controller.
// Circular sample buffer with pre-trigger history and masked trigger.
module capture_controller #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [CHANNELS-1:0] din,
  input  logic                arm,
  input  logic                abort,
  input  logic [CHANNELS-1:0] trig_mask,
  input  logic [CHANNELS-1:0] trig_value,
  input  logic                trig_edge_en,
  input  logic [ADDR_W-1:0]   pretrig,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [CHANNELS-1:0] wr_data,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   start_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t              r_state;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_pretrig;
  logic                r_prev_match;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [CHANNELS-1:0] r_wr_data;
  logic                r_triggered;
  logic                r_done;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic [ADDR_W-1:0]   r_start_addr;

  state_t              w_state;
  logic [ADDR_W-1:0]   w_ptr;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [ADDR_W-1:0]   w_cnt;
  logic [ADDR_W-1:0]   w_pretrig;
  logic [ADDR_W-1:0]   w_post;
  logic                w_prev_match;
  logic                w_match;
  logic                w_fire;
  logic                w_active;
  logic                w_sample;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [CHANNELS-1:0] w_wr_data;
  logic                w_triggered;
  logic                w_done;
  logic [ADDR_W-1:0]   w_trig_addr;
  logic [ADDR_W-1:0]   w_start_addr;

  assign w_active  = (r_state == S_PRE) || (r_state == S_WAIT) ||
                     (r_state == S_POST);
  assign w_sample  = ce && w_active && !abort;
  assign w_ptr_inc = r_ptr + ONE;
  assign w_post    = LAST - r_pretrig;
  assign w_match   = ((r_sync2 ^ trig_value) & trig_mask) == '0;
  assign w_fire    = w_match && (!trig_edge_en || !r_prev_match);

  // Two-stage synchronizer for the asynchronous probes, free running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Capture state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_pretrig    <= '0;
      r_prev_match <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
    end else begin
      r_state      <= w_state;
      r_ptr        <= w_ptr;
      r_cnt        <= w_cnt;
      r_pretrig    <= w_pretrig;
      r_prev_match <= w_prev_match;
      r_wr_en      <= w_wr_en;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_triggered  <= w_triggered;
      r_done       <= w_done;
      r_trig_addr  <= w_trig_addr;
      r_start_addr <= w_start_addr;
    end
  end

  // Next-state: arm/abort control, sample writes, trigger and fill count.
  always_comb begin
    w_state      = r_state;
    w_ptr        = r_ptr;
    w_cnt        = r_cnt;
    w_pretrig    = r_pretrig;
    w_prev_match = r_prev_match;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_addr;
    w_wr_data    = r_wr_data;
    w_triggered  = r_triggered;
    w_done       = r_done;
    w_trig_addr  = r_trig_addr;
    w_start_addr = r_start_addr;

    if (w_sample) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_ptr;
      w_wr_data = r_sync2;
      w_ptr     = w_ptr_inc;
    end

    if (abort) begin
      w_state      = S_IDLE;
      w_triggered  = 1'b0;
      w_done       = 1'b0;
      w_start_addr = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            w_pretrig    = pretrig;
            w_ptr        = '0;
            w_cnt        = pretrig;
            w_prev_match = 1'b1;
            w_triggered  = 1'b0;
            w_done       = 1'b0;
            w_state      = (pretrig == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (ce) begin
            w_prev_match = w_match;
            w_cnt        = r_cnt - ONE;
            if (r_cnt == ONE) w_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ce) begin
            w_prev_match = w_match;
            if (w_fire) begin
              w_trig_addr = r_ptr;
              w_triggered = 1'b1;
              w_cnt       = w_post;
              if (w_post == '0) begin
                w_state      = S_DONE;
                w_done       = 1'b1;
                w_start_addr = w_ptr_inc;
              end else begin
                w_state = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (ce) begin
            w_cnt = r_cnt - ONE;
            if (r_cnt == ONE) begin
              w_state      = S_DONE;
              w_done       = 1'b1;
              w_start_addr = w_ptr_inc;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = w_active;
  assign triggered  = r_triggered;
  assign done       = r_done;
  assign trig_addr  = r_trig_addr;
  assign start_addr = r_start_addr;

endmodule
